// File: rtl/clk_div_prog_if.sv
// Configuration handshake bundle for clk_div_prog.
// i_cfg_phase exists only when CLK_DIV_PROG_PHASE_EN is defined.
interface clk_div_prog_if #(
  parameter int unsigned W = 16
);
  logic         i_cfg_valid;
  logic         o_cfg_ready;
  logic [W-1:0] i_cfg_div;
  logic [W-1:0] i_cfg_high;
  logic         i_cfg_pulse;
`ifdef CLK_DIV_PROG_PHASE_EN
  logic [W-1:0] i_cfg_phase;
`endif

  modport master (
`ifdef CLK_DIV_PROG_PHASE_EN
    output i_cfg_phase,
`endif
    output i_cfg_valid, i_cfg_div, i_cfg_high, i_cfg_pulse,
    input  o_cfg_ready
  );

  modport slave (
`ifdef CLK_DIV_PROG_PHASE_EN
    input  i_cfg_phase,
`endif
    input  i_cfg_valid, i_cfg_div, i_cfg_high, i_cfg_pulse,
    output o_cfg_ready
  );
endinterface

// File: rtl/clk_div_prog.sv
// Runtime-programmable clock/strobe divider with period-boundary config apply.
// Optional programmable start phase: define CLK_DIV_PROG_PHASE_EN.
module clk_div_prog #(
  parameter int unsigned W             = 16,
  parameter int unsigned DEFAULT_DIV   = 2,
  parameter bit          DEFAULT_PULSE = 1'b0
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_en,
  input  logic          i_sync,
  clk_div_prog_if.slave cfg,
  output logic          o_clk,
  output logic          o_tick,
  output logic [W-1:0]  o_cnt
);

  typedef enum logic {ST_STOP, ST_RUN} state_e;

  typedef struct packed {
    logic [W-1:0] div;
    logic [W-1:0] hi;
    logic         pulse;
    logic [W-1:0] phase;
  } cfg_t;

  localparam logic [W-1:0] DIV_RST = (DEFAULT_DIV < 2) ? W'(2) : W'(DEFAULT_DIV);

  state_e       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  cfg_t         cur_q, cur_d;
  cfg_t         pend_q, pend_d;
  logic         pend_v_q, pend_v_d;
  logic         clk_q, clk_d;
  logic         tick_q, tick_d;
  cfg_t         cfg_in;
  logic         apply;
  logic         restart;

  // Clamp at capture so every stored period shows both output levels.
  always_comb begin
    cfg_in.div   = (cfg.i_cfg_div < W'(2)) ? W'(2) : cfg.i_cfg_div;
    cfg_in.pulse = cfg.i_cfg_pulse;
    if (cfg.i_cfg_high == '0) begin
      cfg_in.hi = W'(1);
    end else if (cfg.i_cfg_high >= cfg_in.div) begin
      cfg_in.hi = cfg_in.div - W'(1);
    end else begin
      cfg_in.hi = cfg.i_cfg_high;
    end
`ifdef CLK_DIV_PROG_PHASE_EN
    cfg_in.phase = (cfg.i_cfg_phase >= cfg_in.div) ? cfg_in.div - W'(1) : cfg.i_cfg_phase;
`else
    cfg_in.phase = '0;
`endif
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cur_d    = cur_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    apply    = 1'b0;
    restart  = 1'b0;

    case (state_q)
      ST_STOP: begin
        cnt_d = '0;
        apply = pend_v_q;
        if (i_en) begin
          state_d = ST_RUN;
          restart = 1'b1;
        end
      end
      ST_RUN: begin
        if (!i_en) begin
          state_d = ST_STOP;
          cnt_d   = '0;
        end else if (i_sync) begin
          apply   = pend_v_q;
          restart = 1'b1;
        end else if (cnt_q >= cur_q.div - W'(1)) begin
          // A plain wrap restarts at 0; only an applied config reloads its phase.
          apply   = pend_v_q;
          restart = pend_v_q;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + W'(1);
        end
      end
      default: state_d = ST_STOP;
    endcase

    if (apply) begin
      cur_d    = pend_q;
      pend_v_d = 1'b0;
    end
    if (restart) begin
      cnt_d = cur_d.phase;
    end

    // Capture uses the registered slot state, so a same-edge boundary cannot consume it.
    if (cfg.i_cfg_valid && !pend_v_q) begin
      pend_d   = cfg_in;
      pend_v_d = 1'b1;
    end

    tick_d = (state_d == ST_RUN) && (cnt_d == '0);
    if (state_d != ST_RUN) begin
      clk_d = 1'b0;
    end else if (cur_d.pulse) begin
      clk_d = (cnt_d == '0);
    end else begin
      clk_d = (cnt_d < cur_d.hi);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= ST_STOP;
      cnt_q        <= '0;
      cur_q.div    <= DIV_RST;
      cur_q.hi     <= DIV_RST >> 1;
      cur_q.pulse  <= DEFAULT_PULSE;
      cur_q.phase  <= '0;
      pend_q       <= '0;
      pend_v_q     <= 1'b0;
      clk_q        <= 1'b0;
      tick_q       <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cur_q    <= cur_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      clk_q    <= clk_d;
      tick_q   <= tick_d;
    end
  end

  assign cfg.o_cfg_ready = !pend_v_q;
  assign o_clk           = clk_q;
  assign o_tick          = tick_q;
  assign o_cnt           = cnt_q;

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
Runtime-programmable clock/strobe divider. It is the successor to the fixed-N divider and adds:
- W-bit divisor and high-time, both reconfigurable with a valid/ready handshake;
- square or pulse mode selectable at runtime;
- enable, phase-resync input and period-start tick.

Used for sample-rate generation, LED/PWM timing and realignable frame strobes in breakout firmware. All outputs are registered (glitch-free), in the i_clk domain.

Parameters:
W, 16, width of divisor/high-time/counter.
DEFAULT_DIV, 2, divisor loaded at reset (clamped per cfg rules).
DEFAULT_PULSE, 0, mode at reset: 0 = square, 1 = one-cycle pulse.

Ports:
i_clk  in  1  system clock, single clock domain.
i_reset  in  1  synchronous, active-high reset.
i_en  in  1  run enable, level.
i_sync  in  1  one-cycle phase realign request.
i_cfg_valid  in  1  config offer.
o_cfg_ready  out  1  config slot free.
i_cfg_div  in  W  new divisor (period in i_clk cycles).
i_cfg_high  in  W  new high time in cycles (square mode).
i_cfg_pulse  in  1  new mode.
o_clk  out  1  divided clock / strobe.
o_tick  out  1  one-cycle strobe at each period start.
o_cnt  out  W  current phase counter (debug/phase read).

Behaviour:
- Reset (synchronous, active-high, overrides everything):
  - cnt=0, running=0, o_clk=0, o_tick=0, o_cfg_ready=1, pending discarded.
  - div_q=clamp(DEFAULT_DIV), hi_q=div_q/2, pulse_q=DEFAULT_PULSE.
- Clamping on load:
  - div = max(i_cfg_div, 2).
  - Square mode: high = 1 if i_cfg_high==0; high = div-1 if i_cfg_high>=div; otherwise high = i_cfg_high.
  - Result: both output levels always appear in every period.
- Handshake:
  - Transfer occurs on an edge with i_cfg_valid && o_cfg_ready; the config is stored into the pending register and o_cfg_ready drops on the next cycle.
  - o_cfg_ready = !pending_v.
- Applying a pending config:
  - If running: on the edge where cnt wraps to 0 (boundary) or where a sync takes effect; the new period starts with the new values.
  - If not running: on the next edge.
  - A config accepted on the same edge as a boundary waits for the next boundary.
  - o_cfg_ready returns high on the cycle after apply. There is no mid-period change, so no runt pulse.
- Counter while running:
  - cnt <= (cnt >= div_q-1) ? 0 : cnt+1.
  - The >= guards against a stale count after a config change.
  - Period = div_q cycles.
- Output alignment: o_clk and o_tick are computed from the next-state cnt and registered, so they are aligned with cnt.
  - Square mode: o_clk=1 iff running && cnt < hi_q.
  - Pulse mode: o_clk=1 iff running && cnt==0.
  - o_tick=1 iff running && cnt==0 (both modes).
- Enable:
  - First edge sampling i_en=1 while stopped: running<=1, cnt<=0, so o_clk and o_tick are both high that cycle.
  - Edge sampling i_en=0: running<=0, cnt<=0, o_clk<=0 immediately; the current period is truncated.
- Sync:
  - An edge sampling i_sync=1 while running forces cnt<=0 (new period starts, o_tick=1) and applies any pending config.
  - Ignored when not running. i_en=0 wins over i_sync.
- o_cnt = cnt.

Optional Feature:
CLK_DIV_PROG_PHASE_EN.
- Defined:
  - Adds input i_cfg_phase [W], captured with each config transfer.
  - Clamped to div-1.
  - On enable start, sync and config apply, cnt loads phase instead of 0, giving a programmable phase offset; o_tick still fires only at cnt==0.
- Not defined:
  - No port; the start value is always 0.

Test Plan:
- Reset, DEFAULT_DIV=4, DEFAULT_PULSE=0, i_en=1 -> o_clk 1,1,0,0 repeating; o_tick on every 4th cycle; first high in the cycle after the first edge sampling i_en=1.
- Config div=5, high=2 while running at div=4 -> o_cfg_ready low until the next wrap; the old period completes as 1,1,0,0; then 1,1,0,0,0; ready high the cycle after apply.
- Config div=1, high=0, then div=6, high=9 -> clamped to div=2/high=1 (1,0) and div=6/high=5 (1,1,1,1,1,0).
- Pulse mode div=3 -> o_clk = o_tick = 1,0,0 repeating; i_sync at cnt=1 -> cnt=0 on the next cycle with o_clk=1; period restarts.
- i_en drop mid-high -> o_clk=0 and o_cnt=0 next cycle; i_en and i_sync high on the same edge with running=1 then i_en low -> stopped; reset mid-period with a pending cfg -> defaults restored, pending lost, o_cfg_ready=1.
- (CLK_DIV_PROG_PHASE_EN) div=4, high=2, phase=2 -> after enable, o_cnt 2,3,0,1; o_clk 0,0,1,1; o_tick at o_cnt=0.
